// File: rtl/sdram_resp_model.sv
// SDR SDRAM device-side responder: decodes pad commands, tracks open rows and
// the mode register, stores data in a small array and returns CAS-latency reads.
module sdram_resp_model #(
  parameter int unsigned ROW_WIDTH = 13,
  parameter int unsigned COL_WIDTH = 9,
  parameter int unsigned BA_WIDTH  = 2,
  parameter int unsigned DQ_WIDTH  = 16,
  parameter int unsigned MEM_AW    = 10
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_rst_n,
  input  logic                  cke_pad_i,
  input  logic                  cs_n_pad_i,
  input  logic                  ras_pad_i,
  input  logic                  cas_pad_i,
  input  logic                  we_pad_i,
  input  logic [BA_WIDTH-1:0]   ba_pad_i,
  input  logic [ROW_WIDTH-1:0]  a_pad_i,
  input  logic [DQ_WIDTH/8-1:0] dqm_pad_i,
  input  logic [DQ_WIDTH-1:0]   dq_i,
  output logic [DQ_WIDTH-1:0]   dq_o,
  output logic                  dq_oe,
  output logic [ROW_WIDTH-1:0]  mode_reg_o,
  output logic [3:0]            err_o
);

  localparam int unsigned NumBanks = 2 ** BA_WIDTH;
  localparam int unsigned DmWidth  = DQ_WIDTH / 8;

  typedef enum logic [2:0] {
    CmdMrs = 3'b000, CmdRef = 3'b001, CmdPre = 3'b010, CmdAct = 3'b011,
    CmdWr  = 3'b100, CmdRd  = 3'b101, CmdBst = 3'b110, CmdNop = 3'b111
  } cmd_e;

  logic [ROW_WIDTH-1:0] mode_q, mode_d;
  logic [3:0]           err_q, err_d;
  logic [NumBanks-1:0]  open_q, open_d;
  logic [ROW_WIDTH-1:0] row_q [NumBanks];
  logic [ROW_WIDTH-1:0] row_d [NumBanks];

  // Active burst engine (beats after the first one)
  logic                 bst_act_q, bst_act_d, bst_wr_q, bst_wr_d;
  logic                 bst_full_q, bst_full_d, bst_ap_q, bst_ap_d;
  logic [BA_WIDTH-1:0]  bst_ba_q, bst_ba_d;
  logic [ROW_WIDTH-1:0] bst_row_q, bst_row_d;
  logic [COL_WIDTH-1:0] bst_col_q, bst_col_d, bst_cnt_q, bst_cnt_d, bst_mask_q, bst_mask_d;

  // Read latency pipeline and output registers
  logic                 p0_vld_q, p0_vld_d, p1_vld_q, p1_vld_d;
  logic [MEM_AW-1:0]    p0_idx_q, p0_idx_d, p1_idx_q, p1_idx_d;
  logic [DmWidth-1:0]   dqm_dly_q, dqm_dly_d;
  logic                 dq_oe_q, dq_oe_d;
  logic [DQ_WIDTH-1:0]  dq_q, dq_d;

  logic [DQ_WIDTH-1:0]  mem_q [2**MEM_AW];

  cmd_e                 cmd;
  logic                 bank_hit, rw_go, wr_go, term, cl2, bl_full, new_single, new_full;
  logic [COL_WIDTH-1:0] bl_mask, new_mask, beat_col;
  logic                 beat_vld, beat_wr, beat_last, beat_ap, src_vld;
  logic [BA_WIDTH-1:0]  beat_ba;
  logic [MEM_AW-1:0]    beat_idx, src_idx;

  assign cmd      = (cke_pad_i && !cs_n_pad_i) ? cmd_e'({ras_pad_i, cas_pad_i, we_pad_i}) : CmdNop;
  assign bank_hit = open_q[ba_pad_i];
  assign rw_go    = ((cmd == CmdRd) || (cmd == CmdWr)) && bank_hit;
  assign wr_go    = rw_go && (cmd == CmdWr);
  assign term     = (cmd == CmdBst) || (cmd == CmdPre);
  assign cl2      = (mode_q[6:4] == 3'd2);

  // Burst length decode; reserved codes behave as BL1
  always_comb begin
    bl_mask = '0;
    bl_full = 1'b0;
    unique case (mode_q[2:0])
      3'b001:  bl_mask = COL_WIDTH'(1);
      3'b010:  bl_mask = COL_WIDTH'(3);
      3'b011:  bl_mask = COL_WIDTH'(7);
      3'b111:  begin bl_mask = '1; bl_full = 1'b1; end
      default: ;
    endcase
  end

  assign new_single = wr_go && mode_q[9];
  assign new_mask   = new_single ? '0 : bl_mask;
  assign new_full   = !new_single && bl_full;

  // Beat issued at this edge: beat 0 straight from the command, later beats from the engine
  always_comb begin
    beat_vld  = 1'b0;
    beat_wr   = 1'b0;
    beat_last = 1'b0;
    beat_ap   = 1'b0;
    beat_ba   = bst_ba_q;
    beat_col  = '0;
    beat_idx  = '0;
    if (rw_go) begin
      beat_vld  = 1'b1;
      beat_wr   = wr_go;
      beat_col  = a_pad_i[COL_WIDTH-1:0];
      beat_idx  = MEM_AW'({ba_pad_i, row_q[ba_pad_i], beat_col});
      beat_last = !new_full && (new_mask == '0);
      beat_ap   = a_pad_i[10];
      beat_ba   = ba_pad_i;
    end else if (cke_pad_i && bst_act_q && !term) begin
      beat_vld  = 1'b1;
      beat_wr   = bst_wr_q;
      beat_col  = (bst_col_q & ~bst_mask_q) | ((bst_col_q + bst_cnt_q) & bst_mask_q);
      beat_idx  = MEM_AW'({bst_ba_q, bst_row_q, beat_col});
      beat_last = !bst_full_q && (bst_cnt_q == bst_mask_q);
      beat_ap   = bst_ap_q;
    end
  end

  // Command effects on banks, mode, errors and the burst engine
  always_comb begin
    mode_d     = mode_q;
    err_d      = err_q;
    open_d     = open_q;
    row_d      = row_q;
    bst_act_d  = bst_act_q;
    bst_wr_d   = bst_wr_q;
    bst_full_d = bst_full_q;
    bst_ap_d   = bst_ap_q;
    bst_ba_d   = bst_ba_q;
    bst_row_d  = bst_row_q;
    bst_col_d  = bst_col_q;
    bst_cnt_d  = bst_cnt_q;
    bst_mask_d = bst_mask_q;
    if (beat_vld && beat_last && beat_ap) open_d[beat_ba] = 1'b0;
    unique case (cmd)
      CmdMrs: begin
        if (|open_q) begin
          err_d[2] = 1'b1;
        end else begin
          mode_d = a_pad_i;
          if (a_pad_i[3] || (a_pad_i[2:0] inside {3'b100, 3'b101, 3'b110}) ||
              ((a_pad_i[6:4] != 3'd2) && (a_pad_i[6:4] != 3'd3))) err_d[3] = 1'b1;
        end
      end
      CmdRef: if (|open_q) err_d[2] = 1'b1;
      CmdPre: begin
        if (a_pad_i[10]) open_d = '0;
        else             open_d[ba_pad_i] = 1'b0;
      end
      CmdAct: begin
        if (open_q[ba_pad_i]) begin
          err_d[1] = 1'b1;
        end else begin
          open_d[ba_pad_i] = 1'b1;
          row_d[ba_pad_i]  = a_pad_i;
        end
      end
      CmdWr, CmdRd: if (!bank_hit) err_d[0] = 1'b1;
      default: ;
    endcase
    if (rw_go) begin
      bst_act_d  = !beat_last;
      bst_wr_d   = wr_go;
      bst_ba_d   = ba_pad_i;
      bst_row_d  = row_q[ba_pad_i];
      bst_col_d  = a_pad_i[COL_WIDTH-1:0];
      bst_cnt_d  = COL_WIDTH'(1);
      bst_mask_d = new_mask;
      bst_full_d = new_full;
      bst_ap_d   = a_pad_i[10];
    end else if (term) begin
      bst_act_d = 1'b0;
    end else if (beat_vld) begin
      bst_cnt_d = bst_cnt_q + COL_WIDTH'(1);
      if (beat_last) bst_act_d = 1'b0;
    end
  end

  assign src_vld = cl2 ? p0_vld_q : p1_vld_q;
  assign src_idx = cl2 ? p0_idx_q : p1_idx_q;

  // Read pipeline; a WRITE flushes undriven read beats, cke low freezes everything
  always_comb begin
    p0_vld_d  = p0_vld_q;
    p0_idx_d  = p0_idx_q;
    p1_vld_d  = p1_vld_q;
    p1_idx_d  = p1_idx_q;
    dqm_dly_d = dqm_dly_q;
    dq_oe_d   = dq_oe_q;
    dq_d      = dq_q;
    if (cke_pad_i) begin
      p0_vld_d  = beat_vld && !beat_wr;
      p0_idx_d  = beat_idx;
      p1_vld_d  = p0_vld_q && !wr_go;
      p1_idx_d  = p0_idx_q;
      dqm_dly_d = dqm_pad_i;
      // dqm sampled one edge earlier gives the two-cycle read mask latency
      dq_oe_d   = src_vld && !(&dqm_dly_q) && !wr_go;
      if (src_vld) dq_d = mem_q[src_idx];
    end
  end

  // State registers
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      mode_q     <= ROW_WIDTH'(32'h030);
      err_q      <= '0;
      open_q     <= '0;
      for (int i = 0; i < int'(NumBanks); i++) row_q[i] <= '0;
      bst_act_q  <= 1'b0;
      bst_wr_q   <= 1'b0;
      bst_full_q <= 1'b0;
      bst_ap_q   <= 1'b0;
      bst_ba_q   <= '0;
      bst_row_q  <= '0;
      bst_col_q  <= '0;
      bst_cnt_q  <= '0;
      bst_mask_q <= '0;
      p0_vld_q   <= 1'b0;
      p0_idx_q   <= '0;
      p1_vld_q   <= 1'b0;
      p1_idx_q   <= '0;
      dqm_dly_q  <= '0;
      dq_oe_q    <= 1'b0;
      dq_q       <= '0;
    end else begin
      mode_q     <= mode_d;
      err_q      <= err_d;
      open_q     <= open_d;
      row_q      <= row_d;
      bst_act_q  <= bst_act_d;
      bst_wr_q   <= bst_wr_d;
      bst_full_q <= bst_full_d;
      bst_ap_q   <= bst_ap_d;
      bst_ba_q   <= bst_ba_d;
      bst_row_q  <= bst_row_d;
      bst_col_q  <= bst_col_d;
      bst_cnt_q  <= bst_cnt_d;
      bst_mask_q <= bst_mask_d;
      p0_vld_q   <= p0_vld_d;
      p0_idx_q   <= p0_idx_d;
      p1_vld_q   <= p1_vld_d;
      p1_idx_q   <= p1_idx_d;
      dqm_dly_q  <= dqm_dly_d;
      dq_oe_q    <= dq_oe_d;
      dq_q       <= dq_d;
    end
  end

  // Storage array, byte writes gated by dqm; contents survive reset
  always_ff @(posedge sdram_clk) begin
    if (beat_vld && beat_wr) begin
      for (int i = 0; i < int'(DmWidth); i++) begin
        if (!dqm_pad_i[i]) mem_q[beat_idx][8*i +: 8] <= dq_i[8*i +: 8];
      end
    end
  end

  assign dq_o       = dq_q;
  assign dq_oe      = dq_oe_q;
  assign mode_reg_o = mode_q;
  assign err_o      = err_q;

endmodule

// File: doc/sdram_resp_model.md
Name: sdram_resp_model

Overview:
- Synthesizable SDR SDRAM responder: the device end of the pad interface driven by wb_sdram_ctrl.
- Decodes cs_n/ras/cas/we commands, tracks per-bank open rows and the mode register, and stores data in a small internal array.
- Returns read bursts at the programmed CAS latency.
- Used for FPGA loopback builds and fast simulation in place of the vendor memory model.
- Flags protocol violations in a sticky error register.

Parameters:
- ROW_WIDTH, 13, row address width.
- COL_WIDTH, 9, column address width.
- BA_WIDTH, 2, bank address width.
- DQ_WIDTH, 16, data width; DQM width = DQ_WIDTH/8.
- MEM_AW, 10, internal storage address width (2^MEM_AW words).

Ports:
- sdram_clk  in  1  clock; all sampling on rising edge.
- sdram_rst_n  in  1  reset, asynchronous, active-low.
- cke_pad_i  in  1  clock enable.
- cs_n_pad_i  in  1  chip select, active-low.
- ras_pad_i  in  1  RAS#, active-low.
- cas_pad_i  in  1  CAS#, active-low.
- we_pad_i  in  1  WE#, active-low.
- ba_pad_i  in  BA_WIDTH  bank address.
- a_pad_i  in  ROW_WIDTH  address/mode bus; a[10] = auto-precharge / all-banks.
- dqm_pad_i  in  DQ_WIDTH/8  byte masks; bit0 = dq[7:0].
- dq_i  in  DQ_WIDTH  write data.
- dq_o  out  DQ_WIDTH  read data.
- dq_oe  out  1  read data drive enable.
- mode_reg_o  out  ROW_WIDTH  current mode register.
- err_o  out  4  sticky error flags.

Behaviour:
- Reset (async, immediate): dq_oe=0, dq_o=0, err_o=0, mode_reg_o=0x030 (CL3, BL1, sequential), all banks closed, read/write bursts cancelled. Memory contents not reset.
- Command sampling: only when cke=1 and cs_n=0; otherwise NOP.
- cke=0 freezes all burst counters and pipelines and holds outputs.
- Command encoding {ras,cas,we}:
  - 000 MRS
  - 001 REF
  - 010 PRE
  - 011 ACT
  - 100 WRITE
  - 101 READ
  - 110 BST
  - 111 NOP
- MRS: legal only with all banks closed; loads mode_reg from a. Otherwise ignored and err[2] set.
  - BL from a[2:0]: 000=1, 001=2, 010=4, 011=8, 111=full page (2^COL_WIDTH).
  - CL from a[6:4]: 2 or 3.
  - a[9]=1: writes are single-beat.
  - a[3]=1 (interleaved), reserved BL, or CL not 2/3: err[3] set and the register is still loaded. Reserved BL behaves as 1; illegal CL behaves as 3.
- ACT: opens bank ba with row a. ACT to an already-open bank: err[1], row unchanged.
- PRE: a[10]=1 closes all banks; else closes bank ba. Terminates any active burst as BST does. PRE of a closed bank is legal.
- REF: with any bank open, err[2]; no other effect.
- READ/WRITE to a closed bank: err[0]; command ignored, active burst continues.
- Storage index: LSBs of {ba, open row, col}, truncated to MEM_AW.
- Burst column order: sequential, wrapping within the BL-aligned block; full page wraps the whole row until terminated.
- a[10]=1 on READ/WRITE: bank closes after the final beat.
- READ at edge N:
  - Beat k is registered on edge N+CL-1+k, so the controller samples it at edge N+CL+k.
  - Data is fetched from the array at registration time, so earlier writes are visible.
  - dq_oe=1 for each unmasked beat.
  - Read DQM latency is 2: dqm at edge M forces dq_oe=0 for the beat sampled at edge M+2.
- WRITE at edge N:
  - Beat k is captured from dq_i at edge N+k.
  - dqm bit=1 preserves that byte (DQM latency 0).
  - Captured data is readable from edge N+k+1.
- New READ/WRITE during a burst: terminates the old burst at that edge.
  - For READ→WRITE, read beats not yet driven are dropped and dq_oe=0 from the WRITE edge.
  - For WRITE→READ, write capture stops at the READ edge.
- BST/PRE at edge M: no read beat is sampled at edge ≥ M+CL; write capture stops at M.
- Simultaneous error conditions in one cycle: all corresponding bits set. err_o clears only on reset.

Test Plan:
- Reset release -> dq_oe=0, err_o=0, mode_reg_o=0x030; NOP/deselected cycles change nothing.
- MRS 0x023 (CL2, BL8); ACT ba=1 row=5; WRITE col=4 with dq 0x1000..0x1007 on consecutive edges; READ col=4 at edge N -> controller samples 0x1000..0x1007 at edges N+2..N+9, dq_oe=0 at N+10.
- WRITE 0xAAAA; WRITE same col 0x5555 with dqm=2'b10; READ -> 0xAA55.
- READ to closed bank 2 -> err_o=4'b0001, dq_oe stays 0. Then ACT bank 1 twice -> err_o=4'b0011.
- MRS 0x037 (CL3, full page); READ at edge N, BST at N+2 -> exactly beats sampled at N+3 and N+4. dqm=2'b11 at N+1 -> beat at N+3 has dq_oe=0.
- sdram_rst_n low mid-read-burst -> dq_oe=0 immediately, banks closed, READ after release flags err[0].
